// File: rtl/tmod_cmd_slave.sv
// ============================================================================
// Module   : tmod_cmd_slave
// Brief    : Command-side slave of the temperature monitor bus. Tracks the
//            current/min/max sample, threshold alarms, and answers 4-bit
//            op / 8-bit operand commands with a registered status and result.
// Options  : TMOD_AVG_EN builds the 8-sample running average (op 7).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmod_cmd_slave (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] op,
    input  logic [7:0] opnd,
    input  logic [7:0] temp_in,
    input  logic       temp_strobe,
    output logic [1:0] status,
    output logic       valid,
    output logic       ready,
    output logic [7:0] data_out,
    output logic       alarm_hi,
    output logic       alarm_lo
);

    localparam logic [1:0] c_ST_OK     = 2'b00;
    localparam logic [1:0] c_ST_BADOP  = 2'b01;
    localparam logic [1:0] c_ST_RANGE  = 2'b10;
    localparam logic [1:0] c_ST_NODATA = 2'b11;

    localparam logic [3:0] c_OP_NOP      = 4'd0;
    localparam logic [3:0] c_OP_SET_HI   = 4'd1;
    localparam logic [3:0] c_OP_SET_LO   = 4'd2;
    localparam logic [3:0] c_OP_READ_CUR = 4'd3;
    localparam logic [3:0] c_OP_READ_MAX = 4'd4;
    localparam logic [3:0] c_OP_READ_MIN = 4'd5;
    localparam logic [3:0] c_OP_CLR      = 4'd6;
`ifdef TMOD_AVG_EN
    localparam logic [3:0] c_OP_READ_AVG = 4'd7;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [7:0] opnd_q, opnd_d;
    logic [1:0] status_q, status_d;
    logic [7:0] data_q, data_d;
    logic [7:0] hi_thr_q, hi_thr_d;
    logic [7:0] lo_thr_q, lo_thr_d;
    logic       thr_wr_q, thr_wr_d;
    logic [7:0] cur_q, cur_d;
    logic [7:0] max_q, max_d;
    logic [7:0] min_q, min_d;
    logic       have_data_q, have_data_d;
    logic       alarm_hi_q, alarm_hi_d;
    logic       alarm_lo_q, alarm_lo_d;
    logic       w_clr;

`ifdef TMOD_AVG_EN
    logic [7:0]  hist_q [8];
    logic [7:0]  hist_d [8];
    logic [10:0] sum_q, sum_d;
    logic [3:0]  fill_q, fill_d;
`endif

    // Command FSM: accept in IDLE, execute and register the response in EXEC.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        status_d = status_q;
        data_d   = data_q;
        hi_thr_d = hi_thr_q;
        lo_thr_d = lo_thr_q;
        thr_wr_d = 1'b0;
        w_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (op != c_OP_NOP) begin
                    op_d    = op;
                    opnd_d  = opnd;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d  = RESP;
                status_d = c_ST_OK;
                data_d   = 8'h00;
                case (op_q)
                    c_OP_SET_HI: begin
                        if (opnd_q < lo_thr_q) begin
                            status_d = c_ST_RANGE;
                        end else begin
                            hi_thr_d = opnd_q;
                            thr_wr_d = 1'b1;
                        end
                    end
                    c_OP_SET_LO: begin
                        if (opnd_q > hi_thr_q) begin
                            status_d = c_ST_RANGE;
                        end else begin
                            lo_thr_d = opnd_q;
                            thr_wr_d = 1'b1;
                        end
                    end
                    c_OP_READ_CUR, c_OP_READ_MAX, c_OP_READ_MIN: begin
                        if (!have_data_q) begin
                            status_d = c_ST_NODATA;
                        end else if (op_q == c_OP_READ_CUR) begin
                            data_d = cur_q;
                        end else if (op_q == c_OP_READ_MAX) begin
                            data_d = max_q;
                        end else begin
                            data_d = min_q;
                        end
                    end
                    c_OP_CLR: begin
                        w_clr = 1'b1;
                    end
`ifdef TMOD_AVG_EN
                    c_OP_READ_AVG: begin
                        if (fill_q != 4'd8) begin
                            status_d = c_ST_NODATA;
                        end else begin
                            data_d = sum_q[10:3];
                        end
                    end
`endif
                    default: begin
                        status_d = c_ST_BADOP;
                    end
                endcase
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sample path runs every cycle; a coincident clear beats the strobe
    // for the statistics but not for the current sample.
    always_comb begin
        cur_d       = cur_q;
        max_d       = max_q;
        min_d       = min_q;
        have_data_d = have_data_q;
        if (temp_strobe) begin
            cur_d = temp_in;
        end
        if (w_clr) begin
            max_d       = 8'h00;
            min_d       = 8'hFF;
            have_data_d = 1'b0;
        end else if (temp_strobe) begin
            max_d       = (temp_in > max_q) ? temp_in : max_q;
            min_d       = (temp_in < min_q) ? temp_in : min_q;
            have_data_d = 1'b1;
        end
    end

    always_comb begin
        alarm_hi_d = alarm_hi_q;
        alarm_lo_d = alarm_lo_q;
        if (w_clr) begin
            alarm_hi_d = 1'b0;
            alarm_lo_d = 1'b0;
        end else if (temp_strobe) begin
            alarm_hi_d = (temp_in > hi_thr_q);
            alarm_lo_d = (temp_in < lo_thr_q);
        end else if (thr_wr_q && have_data_q) begin
            alarm_hi_d = (cur_q > hi_thr_q);
            alarm_lo_d = (cur_q < lo_thr_q);
        end else if (!have_data_q) begin
            alarm_hi_d = 1'b0;
            alarm_lo_d = 1'b0;
        end
    end

`ifdef TMOD_AVG_EN
    // Running sum tracks the eight history slots; empty slots hold zero.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            hist_d[i] = hist_q[i];
        end
        sum_d  = sum_q;
        fill_d = fill_q;
        if (w_clr) begin
            for (int i = 0; i < 8; i++) begin
                hist_d[i] = 8'h00;
            end
            sum_d  = 11'd0;
            fill_d = 4'd0;
        end else if (temp_strobe) begin
            hist_d[0] = temp_in;
            for (int i = 1; i < 8; i++) begin
                hist_d[i] = hist_q[i-1];
            end
            sum_d  = sum_q + {3'b000, temp_in} - {3'b000, hist_q[7]};
            fill_d = (fill_q == 4'd8) ? fill_q : fill_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                hist_q[i] <= 8'h00;
            end
            sum_q  <= 11'd0;
            fill_q <= 4'd0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                hist_q[i] <= hist_d[i];
            end
            sum_q  <= sum_d;
            fill_q <= fill_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 4'd0;
            opnd_q      <= 8'h00;
            status_q    <= c_ST_OK;
            data_q      <= 8'h00;
            hi_thr_q    <= 8'hFF;
            lo_thr_q    <= 8'h00;
            thr_wr_q    <= 1'b0;
            cur_q       <= 8'h00;
            max_q       <= 8'h00;
            min_q       <= 8'hFF;
            have_data_q <= 1'b0;
            alarm_hi_q  <= 1'b0;
            alarm_lo_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opnd_q      <= opnd_d;
            status_q    <= status_d;
            data_q      <= data_d;
            hi_thr_q    <= hi_thr_d;
            lo_thr_q    <= lo_thr_d;
            thr_wr_q    <= thr_wr_d;
            cur_q       <= cur_d;
            max_q       <= max_d;
            min_q       <= min_d;
            have_data_q <= have_data_d;
            alarm_hi_q  <= alarm_hi_d;
            alarm_lo_q  <= alarm_lo_d;
        end
    end

    assign ready    = (state_q == IDLE);
    assign valid    = (state_q == RESP);
    assign status   = status_q;
    assign data_out = data_q;
    assign alarm_hi = alarm_hi_q;
    assign alarm_lo = alarm_lo_q;

endmodule

`default_nettype wire
